// File: rtl/fpu_div_24_if.sv
// -----------------------------------------------------------------------------
// fpu_div_24_if
//   Operand/result handshake bundle for the fpu_div_24 mantissa divider.
//
//   Parameters
//     WIDTH      mantissa width including hidden bit
//     TAG_WIDTH  sideband tag width
//
//   Signals
//     in_valid / in_ready        operand handshake (upstream -> divider)
//     in_a, in_b, in_tag         dividend, divisor, sideband tag
//     out_valid / out_ready      result handshake (divider -> downstream)
//     out_q                      quotient, 1 integer + WIDTH+1 fraction bits
//     out_sticky                 remainder nonzero
//     out_div_zero               divisor was zero
//     out_tag                    tag captured with the operands
//
//   Modports
//     master  drives operands and out_ready (upstream / test side)
//     slave   the divider itself
// -----------------------------------------------------------------------------
interface fpu_div_24_if #(
  parameter int WIDTH     = 24,
  parameter int TAG_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [TAG_WIDTH-1:0] in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH+1:0]     out_q;
  logic                 out_sticky;
  logic                 out_div_zero;
  logic [TAG_WIDTH-1:0] out_tag;

  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_q, out_sticky, out_div_zero, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_q, out_sticky, out_div_zero, out_tag
  );
endinterface

// File: rtl/fpu_div_24.sv
// -----------------------------------------------------------------------------
// fpu_div_24
//   Iterative radix-2 restoring mantissa divider.
//   out_q = floor(in_a * 2^(WIDTH+1) / in_b), out_sticky = (remainder != 0).
//   One quotient bit per BUSY cycle, WIDTH+2 iterations; a zero divisor skips
//   the iterations and returns q = all ones, sticky = 1, div_zero = 1.
//
//   Ports
//     clk    clock
//     rst_n  asynchronous active-low reset
//     bus    fpu_div_24_if.slave: operand handshake in, result handshake out
//
//   Configuration macro
//     FPU_DIV_EARLY_EXIT_EN  when defined, stop as soon as an iteration leaves
//                            a zero remainder; the remaining quotient bits are
//                            zero-filled so the result is bit-identical.
// -----------------------------------------------------------------------------
module fpu_div_24 #(
  parameter int WIDTH     = 24,
  parameter int TAG_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  fpu_div_24_if.slave    bus
);

  localparam int QW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH + 3);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [QW-1:0]        r_rem;
  logic [WIDTH-1:0]     r_div;
  logic [QW-1:0]        r_q;
  logic [CW-1:0]        r_cnt;
  logic [TAG_WIDTH-1:0] r_tag;
  logic                 r_sticky;
  logic                 r_div_zero;

  logic [QW-1:0]        w_div_ext;
  logic                 w_ge;
  logic [QW-1:0]        w_rem_sub;
  logic [QW-1:0]        w_q_step;
  logic                 w_last;
  logic                 w_exit;
  logic                 w_b_zero;

  // ---------------------------------------------------------------------------
  // Single iteration datapath
  // ---------------------------------------------------------------------------
  assign w_div_ext = {2'b00, r_div};
  assign w_ge      = (r_rem >= w_div_ext);
  assign w_rem_sub = w_ge ? (r_rem - w_div_ext) : r_rem;
  assign w_q_step  = {r_q[QW-2:0], w_ge};
  assign w_last    = (r_cnt == CW'(1));
  assign w_b_zero  = (bus.in_b == '0);

`ifdef FPU_DIV_EARLY_EXIT_EN
  logic w_rem_zero;
  assign w_rem_zero = (w_rem_sub == '0);
  assign w_exit     = w_last || w_rem_zero;
`else
  assign w_exit     = w_last;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_state_next = w_b_zero ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_exit) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs, decoded from the state register only
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      S_IDLE:  bus.in_ready  = 1'b1;
      S_DONE:  bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem      <= '0;
      r_div      <= '0;
      r_q        <= '0;
      r_cnt      <= '0;
      r_tag      <= '0;
      r_sticky   <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_rem <= {2'b00, bus.in_a};
            r_div <= bus.in_b;
            r_tag <= bus.in_tag;
            if (w_b_zero) begin
              // Result is final immediately; no iterations run.
              r_q        <= '1;
              r_sticky   <= 1'b1;
              r_div_zero <= 1'b1;
              r_cnt      <= '0;
            end else begin
              r_q        <= '0;
              r_sticky   <= 1'b0;
              r_div_zero <= 1'b0;
              r_cnt      <= CW'(WIDTH + 2);
            end
          end
        end
        S_BUSY: begin
          // The subtracted remainder is always below the divisor, so the
          // shift never loses a significant bit.
          r_rem <= w_rem_sub << 1;
          r_cnt <= r_cnt - CW'(1);
`ifdef FPU_DIV_EARLY_EXIT_EN
          if (w_rem_zero) begin
            // Zero-fill the quotient bits the skipped iterations would produce.
            r_q   <= w_q_step << (r_cnt - CW'(1));
            r_cnt <= '0;
          end else begin
            r_q <= w_q_step;
          end
`else
          r_q <= w_q_step;
`endif
          if (w_exit) begin
            r_sticky <= (w_rem_sub != '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_q        = r_q;
  assign bus.out_sticky   = r_sticky;
  assign bus.out_div_zero = r_div_zero;
  assign bus.out_tag      = r_tag;

endmodule
